// File: rtl/stim_pulse_sequencer_pkg.sv
// Shared definitions for the biphasic stimulation pulse sequencer:
// state encodings, default timing constants and the per-state drive pattern.
package stim_pulse_sequencer_pkg;

    localparam int unsigned PW_UNIT_DEF   = 4;
    localparam int unsigned IPG_CYC_DEF   = 2;
    localparam int unsigned IDLE_UNIT_DEF = 16;
    localparam int unsigned CNT_W         = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_IPG  = 3'd2,
        S_PH2  = 3'd3,
        S_REST = 3'd4
    } state_t;

    typedef struct packed {
        logic ano_top;
        logic ano_bot;
        logic cat_top;
        logic cat_bot;
        logic curr_ena;
    } drive_t;

    // Only the two active phases close a diagonal of the H-bridge; every
    // other state leaves all switches open and the current source off.
    function automatic drive_t drive_for(input state_t s);
        drive_t d;
        d = '0;
        case (s)
            S_PH1: begin
                d.ano_top  = 1'b1;
                d.cat_bot  = 1'b1;
                d.curr_ena = 1'b1;
            end
            S_PH2: begin
                d.cat_top  = 1'b1;
                d.ano_bot  = 1'b1;
                d.curr_ena = 1'b1;
            end
            default: d = '0;
        endcase
        return d;
    endfunction

    // Counter load value for a state lasting (code+1)*unit cycles.
    function automatic logic [CNT_W-1:0] last_count(input logic [2:0] code,
                                                    input int unsigned unit);
        int unsigned len;
        len = (32'(code) + 32'd1) * unit;
        return CNT_W'(len - 32'd1);
    endfunction

endpackage

// File: rtl/stim_edge_det.sv
// Registers a request level and flags its rising edge for one cycle.
// The first clock after reset seeds both registers so a held level never fires.
module stim_edge_det (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_rise
);

    logic cur;
    logic prev;
    logic armed;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cur   <= 1'b0;
            prev  <= 1'b0;
            armed <= 1'b0;
        end else begin
            armed <= 1'b1;
            cur   <= i_d;
            prev  <= armed ? cur : i_d;
        end
    end

    assign o_rise = cur & ~prev;

endmodule

// File: rtl/stim_pulse_sequencer.sv
// Biphasic charge-balanced pulse train generator driving an H-bridge:
// PH1 (anodic) -> IPG -> PH2 (cathodic) -> REST, repeated until stopped.
module stim_pulse_sequencer
    import stim_pulse_sequencer_pkg::*;
#(
    parameter int unsigned PW_UNIT   = PW_UNIT_DEF,
    parameter int unsigned IPG_CYC   = IPG_CYC_DEF,
    parameter int unsigned IDLE_UNIT = IDLE_UNIT_DEF
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_start,
    input  logic       i_stop,
    input  logic [2:0] i_duty,
    input  logic [2:0] i_idle,
    output logic       o_ano_top,
    output logic       o_ano_bot,
    output logic       o_cat_top,
    output logic       o_cat_bot,
    output logic       o_curr_ena,
    output logic       o_busy,
    output logic       o_done
);

    localparam logic [CNT_W-1:0] IPG_LAST = CNT_W'(IPG_CYC - 1);

    logic             start_rise;
    logic             stop_rise;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       duty_q;
    logic [2:0]       idle_q;
    logic             stop_pend;
    drive_t           drv;
    logic             done;
    logic             cnt_zero;

    stim_edge_det u_start_det (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_start),
        .o_rise (start_rise)
    );

    stim_edge_det u_stop_det (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_d    (i_stop),
        .o_rise (stop_rise)
    );

    assign cnt_zero = (cnt == '0);

    // Drives are loaded together with the state so the bridge switches on
    // exactly the edge that changes phase; no decode glitches reach the pins.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            duty_q    <= '0;
            idle_q    <= '0;
            stop_pend <= 1'b0;
            drv       <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    // A simultaneous stop wins over start.
                    if (start_rise && !stop_rise) begin
                        state     <= S_PH1;
                        cnt       <= last_count(i_duty, PW_UNIT);
                        duty_q    <= i_duty;
                        idle_q    <= i_idle;
                        stop_pend <= 1'b0;
                        drv       <= drive_for(S_PH1);
                    end
                end
                S_PH1: begin
                    if (stop_rise) stop_pend <= 1'b1;
                    if (cnt_zero) begin
                        state <= S_IPG;
                        cnt   <= IPG_LAST;
                        drv   <= drive_for(S_IPG);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_IPG: begin
                    if (stop_rise) stop_pend <= 1'b1;
                    if (cnt_zero) begin
                        state <= S_PH2;
                        cnt   <= last_count(duty_q, PW_UNIT);
                        drv   <= drive_for(S_PH2);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_PH2: begin
                    if (stop_rise) stop_pend <= 1'b1;
                    if (cnt_zero) begin
                        // A pending stop ends here so the cathodic phase
                        // always balances the anodic one; REST is skipped.
                        if (stop_pend || stop_rise) begin
                            state     <= S_IDLE;
                            cnt       <= '0;
                            stop_pend <= 1'b0;
                            drv       <= drive_for(S_IDLE);
                            done      <= 1'b1;
                        end else begin
                            state <= S_REST;
                            cnt   <= last_count(idle_q, IDLE_UNIT);
                            drv   <= drive_for(S_REST);
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_REST: begin
                    if (stop_rise) begin
                        state     <= S_IDLE;
                        cnt       <= '0;
                        stop_pend <= 1'b0;
                        drv       <= drive_for(S_IDLE);
                        done      <= 1'b1;
                    end else if (cnt_zero) begin
                        state  <= S_PH1;
                        cnt    <= last_count(i_duty, PW_UNIT);
                        duty_q <= i_duty;
                        idle_q <= i_idle;
                        drv    <= drive_for(S_PH1);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    cnt   <= '0;
                    drv   <= '0;
                end
            endcase
        end
    end

    assign o_ano_top  = drv.ano_top;
    assign o_ano_bot  = drv.ano_bot;
    assign o_cat_top  = drv.cat_top;
    assign o_cat_bot  = drv.cat_bot;
    assign o_curr_ena = drv.curr_ena;
    assign o_busy     = (state != S_IDLE);
    assign o_done     = done;

endmodule

// File: tb/tb_stim_pulse_sequencer.sv
// Self-checking bench for stim_pulse_sequencer: table of phase-length vectors
// plus directed stop, reset and start/stop-collision sequences.
module tb_stim_pulse_sequencer;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       stop;
    logic [2:0] duty;
    logic [2:0] idle;
    logic       ano_top, ano_bot, cat_top, cat_bot, curr_ena, busy, done;

    int checks       = 0;
    int errors       = 0;
    int overlap_errs = 0;

    // {ano_top, ano_bot, cat_top, cat_bot, curr_ena, busy}
    localparam logic [5:0] P_PH1  = 6'b100111;
    localparam logic [5:0] P_PH2  = 6'b011011;
    localparam logic [5:0] P_OFF  = 6'b000001;
    localparam logic [5:0] P_IDLE = 6'b000000;

    stim_pulse_sequencer dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_start   (start),
        .i_stop    (stop),
        .i_duty    (duty),
        .i_idle    (idle),
        .o_ano_top (ano_top),
        .o_ano_bot (ano_bot),
        .o_cat_top (cat_top),
        .o_cat_bot (cat_bot),
        .o_curr_ena(curr_ena),
        .o_busy    (busy),
        .o_done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shoot-through guard: same-electrode top/bottom switches never on together.
    always @(negedge clk) begin
        assert (!(ano_top && ano_bot) && !(cat_top && cat_bot))
        else overlap_errs++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [2:0] duty;
        logic [2:0] idle;
        int         ph1;
        int         ipg;
        int         ph2;
        int         rest;
    } vec_t;

    vec_t vecs[4];

    function automatic logic [5:0] outs();
        return {ano_top, ano_bot, cat_top, cat_bot, curr_ena, busy};
    endfunction

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic count_while(input logic [5:0] p, input int limit, output int n);
        n = 0;
        while (outs() == p && n < limit) begin
            n++;
            tick();
        end
    endtask

    task automatic wait_for(input string name, input logic [5:0] p, input int limit);
        int n;
        n = 0;
        while (outs() != p && n < limit) begin
            n++;
            tick();
        end
        check(name, int'(outs() == p), 1);
    endtask

    // Two ticks: start is registered, then its edge is seen, then PH1 is entered.
    task automatic start_pulse();
        start = 1'b1;
        tick();
        tick();
        start = 1'b0;
    endtask

    // Raise stop, run until idle, return how many done pulses were seen.
    task automatic stop_to_idle(input string name, output int dones);
        int n;
        dones = 0;
        n     = 0;
        stop  = 1'b1;
        while (busy && n < 400) begin
            n++;
            tick();
            if (done) dones++;
        end
        check({name, " idle"}, int'(busy), 0);
        tick();
        check({name, " done low"}, int'(done), 0);
        stop = 1'b0;
        tick();
        tick();
    endtask

    initial begin
        int n, dn, ph1, ipg, ph2, rest;

        vecs[0] = '{3'd0, 3'd0, 4,  2, 4,  16};
        vecs[1] = '{3'd7, 3'd3, 32, 2, 32, 64};
        vecs[2] = '{3'd2, 3'd1, 12, 2, 12, 32};
        vecs[3] = '{3'd5, 3'd7, 24, 2, 24, 128};

        rst_n = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        duty  = 3'd0;
        idle  = 3'd0;
        #3;
        check("reset outs", int'(outs()), int'(P_IDLE));
        check("reset done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        tick();

        foreach (vecs[i]) begin
            duty = vecs[i].duty;
            idle = vecs[i].idle;
            start_pulse();
            wait_for($sformatf("v%0d enter ph1", i), P_PH1, 8);
            count_while(P_PH1, 300, ph1);
            count_while(P_OFF, 300, ipg);
            count_while(P_PH2, 300, ph2);
            count_while(P_OFF, 300, rest);
            check($sformatf("v%0d ph1", i), ph1, vecs[i].ph1);
            check($sformatf("v%0d ipg", i), ipg, vecs[i].ipg);
            check($sformatf("v%0d ph2", i), ph2, vecs[i].ph2);
            check($sformatf("v%0d rest", i), rest, vecs[i].rest);
            check($sformatf("v%0d repeat ph1", i), int'(outs()), int'(P_PH1));
            if (i == 0) check("v0 period", ph1 + ipg + ph2 + rest, 26);
            stop_to_idle($sformatf("v%0d stop", i), dn);
            check($sformatf("v%0d done pulses", i), dn, 1);
        end

        // i_duty changed mid-PH1 only affects the following biphasic cycle.
        duty = 3'd1;
        idle = 3'd0;
        start_pulse();
        wait_for("dchg enter ph1", P_PH1, 8);
        tick();
        duty = 3'd3;
        count_while(P_PH1, 300, ph1);
        check("dchg ph1", ph1 + 1, 8);
        count_while(P_OFF, 300, ipg);
        count_while(P_PH2, 300, ph2);
        check("dchg ph2", ph2, 8);
        count_while(P_OFF, 300, rest);
        count_while(P_PH1, 300, ph1);
        check("dchg next ph1", ph1, 16);
        stop_to_idle("dchg stop", dn);
        duty = 3'd0;

        // Stop at PH1 cycle 2: PH2 completes, REST is skipped.
        start_pulse();
        wait_for("stop_ph1 enter", P_PH1, 8);
        tick();
        stop = 1'b1;
        count_while(P_PH1, 300, ph1);
        count_while(P_OFF, 300, ipg);
        check("stop_ph1 ipg", ipg, 2);
        count_while(P_PH2, 300, ph2);
        check("stop_ph1 ph2", ph2, 4);
        check("stop_ph1 idle outs", int'(outs()), int'(P_IDLE));
        check("stop_ph1 done", int'(done), 1);
        tick();
        check("stop_ph1 done once", int'(done), 0);
        stop = 1'b0;
        tick();
        tick();

        // Stop in REST cycle 5: idle after the edge detector latency.
        start_pulse();
        wait_for("stop_rest enter", P_PH1, 8);
        count_while(P_PH1, 300, n);
        count_while(P_OFF, 300, n);
        count_while(P_PH2, 300, n);
        repeat (4) tick();
        check("stop_rest in rest", int'(outs()), int'(P_OFF));
        stop = 1'b1;
        count_while(P_OFF, 300, rest);
        check("stop_rest remaining", rest, 2);
        check("stop_rest idle outs", int'(outs()), int'(P_IDLE));
        check("stop_rest done", int'(done), 1);
        tick();
        check("stop_rest done once", int'(done), 0);
        stop = 1'b0;
        tick();
        tick();

        // Start and stop edges together while idle: stop wins; held start never retriggers.
        start = 1'b1;
        stop  = 1'b1;
        n     = 0;
        repeat (8) begin
            tick();
            if (outs() != P_IDLE) n++;
        end
        check("collide activity", n, 0);
        stop = 1'b0;
        repeat (8) begin
            tick();
            if (outs() != P_IDLE) n++;
        end
        check("held start activity", n, 0);

        // Start held high through reset must not start a train.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        repeat (8) begin
            tick();
            if (outs() != P_IDLE) n++;
        end
        check("start through reset", n, 0);
        start = 1'b0;
        tick();
        tick();

        // Reset mid-PH2 drops every drive immediately.
        start_pulse();
        wait_for("rst_ph2 enter", P_PH1, 8);
        count_while(P_PH1, 300, n);
        count_while(P_OFF, 300, n);
        tick();
        check("rst_ph2 in ph2", int'(outs()), int'(P_PH2));
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_ph2 outs async", int'(outs()), int'(P_IDLE));
        check("rst_ph2 done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) tick();
        check("rst_ph2 stays idle", int'(outs()), int'(P_IDLE));

        check("no switch overlap", overlap_errs, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
